imem_arbiter: RTL

- Shares the single-ported, byte-addressed instruction BRAM between two requesters: the instruction-fetch port (IF, read-only) and the load/store/preload port (LS, read/write with byte enables).
- Issues at most one memory access per cycle. Returns responses one cycle after grant, matching the BRAM's 1-cycle synchronous read.
- LS has fixed priority, with a starvation guard for IF and a lock mode for multi-beat preload bursts.

---
 rtl/imem_pkg.sv | 25 ++
 rtl/imem_starve_ctr.sv | 39 +++
 rtl/imem_arbiter.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/imem_pkg.sv
// Shared types and defaults for the instruction-memory arbiter.
// Holds the port id, FSM state and pending-response record used by imem_arbiter.
package imem_pkg;

   localparam int unsigned DEFAULT_MEM_SIZE = 512;
   localparam int unsigned STARVE_W         = 4;

   typedef enum logic {
      PORT_IF = 1'b0,
      PORT_LS = 1'b1
   } port_e;

   typedef enum logic {
      ST_ARB  = 1'b0,
      ST_LOCK = 1'b1
   } state_e;

   typedef struct packed {
      logic  valid;
      port_e port;
      logic  is_write;
      logic  err;
   } pend_t;

endpackage

// File: rtl/imem_starve_ctr.sv
// Saturating starvation counter for the instruction-fetch port.
// Clear has priority over increment; at_limit_o flags a saturated count.
module imem_starve_ctr
   import imem_pkg::*;
#(
   parameter int unsigned LIMIT = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear_i,
   input  logic inc_i,
   output logic at_limit_o
);

   localparam logic [STARVE_W-1:0] LIM = STARVE_W'(LIMIT);

   logic [STARVE_W-1:0] cnt_q;
   logic [STARVE_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clear_i) begin
         cnt_d = '0;
      end else if (inc_i && (cnt_q < LIM)) begin
         cnt_d = cnt_q + STARVE_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign at_limit_o = (cnt_q == LIM);

endmodule

// File: rtl/imem_arbiter.sv
// Arbiter sharing the single-ported instruction BRAM between IF and LS requesters.
// Optional address checking is enabled with the IMEM_BOUNDS_CHECK_EN macro.
module imem_arbiter
   import imem_pkg::*;
#(
   parameter int unsigned ADDR_W       = 32,
   parameter int unsigned MEM_SIZE     = DEFAULT_MEM_SIZE,
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              if_req_i,
   input  logic [ADDR_W-1:0] if_addr_i,
   output logic              if_gnt_o,
   output logic              if_rvalid_o,
   output logic [31:0]       if_rdata_o,
   output logic              if_err_o,
   input  logic              ls_req_i,
   input  logic              ls_we_i,
   input  logic [3:0]        ls_be_i,
   input  logic [ADDR_W-1:0] ls_addr_i,
   input  logic [31:0]       ls_wdata_i,
   input  logic              ls_lock_i,
   output logic              ls_gnt_o,
   output logic              ls_rvalid_o,
   output logic [31:0]       ls_rdata_o,
   output logic              ls_err_o,
   output logic              mem_en_o,
   output logic              mem_we_o,
   output logic [3:0]        mem_be_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [31:0]       mem_wdata_o,
   input  logic [31:0]       mem_rdata_i
);

   state_e state_q;
   state_e state_d;
   pend_t  pend_q;
   pend_t  pend_d;
   logic   active_q;
   logic   starve_at_limit;
   logic   addr_err;

   imem_starve_ctr #(
      .LIMIT (STARVE_LIMIT)
   ) u_starve_ctr (
      .clk        (clk),
      .rst_n      (rst_n),
      .clear_i    (!if_req_i || if_gnt_o),
      .inc_i      (if_req_i && !if_gnt_o),
      .at_limit_o (starve_at_limit)
   );

   // Grants are held off until the first edge after reset has been seen.
   always_comb begin
      if_gnt_o = 1'b0;
      ls_gnt_o = 1'b0;
      state_d  = state_q;
      if (active_q) begin
         unique case (state_q)
            ST_ARB: begin
               if (ls_req_i && !(if_req_i && starve_at_limit)) begin
                  ls_gnt_o = 1'b1;
               end else if (if_req_i) begin
                  if_gnt_o = 1'b1;
               end
               if (ls_gnt_o && ls_lock_i) begin
                  state_d = ST_LOCK;
               end
            end
            ST_LOCK: begin
               ls_gnt_o = ls_req_i;
               if (!ls_lock_i) begin
                  state_d = ST_ARB;
               end
            end
            default: state_d = ST_ARB;
         endcase
      end
   end

`ifdef IMEM_BOUNDS_CHECK_EN
   logic [ADDR_W-1:0] sel_addr;
   logic [ADDR_W:0]   last_byte;

   assign sel_addr  = ls_gnt_o ? ls_addr_i : if_addr_i;
   assign last_byte = {1'b0, sel_addr} + (ADDR_W+1)'(3);
   assign addr_err  = (if_gnt_o || ls_gnt_o) &&
                      ((sel_addr[1:0] != 2'b00) || (last_byte >= (ADDR_W+1)'(MEM_SIZE)));
`else
   assign addr_err = 1'b0;
`endif

   // A rejected address still consumes the grant but never reaches the BRAM.
   always_comb begin
      mem_en_o    = 1'b0;
      mem_we_o    = 1'b0;
      mem_be_o    = '0;
      mem_addr_o  = '0;
      mem_wdata_o = '0;
      if (ls_gnt_o) begin
         mem_en_o    = !addr_err;
         mem_we_o    = ls_we_i && !addr_err;
         mem_be_o    = ls_be_i;
         mem_addr_o  = ls_addr_i;
         mem_wdata_o = ls_wdata_i;
      end else if (if_gnt_o) begin
         mem_en_o   = !addr_err;
         mem_addr_o = if_addr_i;
      end
   end

   always_comb begin
      pend_d          = '0;
      pend_d.valid    = if_gnt_o || ls_gnt_o;
      pend_d.port     = ls_gnt_o ? PORT_LS : PORT_IF;
      pend_d.is_write = ls_gnt_o && ls_we_i;
      pend_d.err      = addr_err;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_ARB;
         pend_q   <= '0;
         active_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         pend_q   <= pend_d;
         active_q <= 1'b1;
      end
   end

   // Read data is forwarded only to the port that owns the pending read.
   always_comb begin
      if_rvalid_o = pend_q.valid && (pend_q.port == PORT_IF);
      ls_rvalid_o = pend_q.valid && (pend_q.port == PORT_LS);
      if_rdata_o  = '0;
      ls_rdata_o  = '0;
      if (if_rvalid_o && !pend_q.is_write && !pend_q.err) begin
         if_rdata_o = mem_rdata_i;
      end
      if (ls_rvalid_o && !pend_q.is_write && !pend_q.err) begin
         ls_rdata_o = mem_rdata_i;
      end
   end

`ifdef IMEM_BOUNDS_CHECK_EN
   assign if_err_o = if_rvalid_o && pend_q.err;
   assign ls_err_o = ls_rvalid_o && pend_q.err;
`else
   assign if_err_o = 1'b0;
   assign ls_err_o = 1'b0;
`endif

endmodule
